// File: rtl/dmt_timing_generator.sv
// dmt_timing_generator
// ---------------------------------------------------------------------------
// Free-running VESA DMT video timing generator, clocked by the pixel clock.
// Default parameters give 1024x768@60 Hz at 65 MHz (H_TOTAL=1344,
// V_TOTAL=806).
//
// Two 12-bit counters walk the raster: h_cnt runs 0..H_TOTAL-1 every cycle,
// v_cnt advances when h_cnt wraps and itself wraps at the frame boundary.
// Region order on both axes is active, front porch, sync, back porch, with
// the active region starting at count 0.
//
// All outputs are registered decodes of the counters, so each output shows
// the decode of the counter value from the previous cycle. After reset is
// released, the first clock edge registers the decode of pixel (0,0), so
// de rises in that cycle and every frame starts at the origin.
//
// Optional feature macro: TIMING_XY_EN
//   When defined, x_pos/y_pos report the active pixel column and line,
//   cycle-aligned with de, and are held at 0 while de is low.
//
// Ports:
//   pixe_clk  in   pixel clock, rising edge
//   rest      in   synchronous reset, active-high
//   vsycn     out  vertical sync, active level set by V_POL
//   hsync     out  horizontal sync, active level set by H_POL
//   de        out  data enable, high during active pixels
//   x_pos     out  [11:0] active column (TIMING_XY_EN only)
//   y_pos     out  [11:0] active line   (TIMING_XY_EN only)
// ---------------------------------------------------------------------------
module dmt_timing_generator #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0
) (
  input  logic        pixe_clk,
  input  logic        rest,
  output logic        vsycn,
  output logic        hsync,
  output logic        de
`ifdef TIMING_XY_EN
  ,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Region boundaries are kept 13 bits wide so a boundary equal to 4096
  // (e.g. zero back porch with a 4096 total) still compares correctly
  // against the 12-bit counters.
  localparam logic [12:0] H_ACT_END  = 13'(H_ACTIVE);
  localparam logic [12:0] H_SYNC_BEG = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_SYNC_END = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT_END  = 13'(V_ACTIVE);
  localparam logic [12:0] V_SYNC_BEG = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] V_SYNC_END = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);

  // Both totals must fit the 12-bit counters.
  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_totals
    $error("dmt_timing_generator: H_TOTAL and V_TOTAL must be <= 4096");
  end

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic        de_q, de_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        h_wrap;
  logic        v_wrap;
  logic [12:0] h_ext;
  logic [12:0] v_ext;
  logic        h_in_sync;
  logic        v_in_sync;

`ifdef TIMING_XY_EN
  logic [11:0] x_pos_q, x_pos_d;
  logic [11:0] y_pos_q, y_pos_d;
`endif

  // Counter next-state and output decode.
  always_comb begin
    h_wrap    = (h_cnt_q == H_LAST);
    v_wrap    = (v_cnt_q == V_LAST);
    h_ext     = {1'b0, h_cnt_q};
    v_ext     = {1'b0, v_cnt_q};

    h_cnt_d   = h_wrap ? 12'd0 : (h_cnt_q + 12'd1);
    v_cnt_d   = v_cnt_q;
    if (h_wrap) begin
      // The frame boundary is the cycle where both counters are at max.
      v_cnt_d = v_wrap ? 12'd0 : (v_cnt_q + 12'd1);
    end

    h_in_sync = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
    // v_cnt only changes when h_cnt wraps, so vsync edges land on the
    // first pixel of a line.
    v_in_sync = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);

    de_d      = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    hsync_d   = h_in_sync ? H_POL : ~H_POL;
    vsync_d   = v_in_sync ? V_POL : ~V_POL;

`ifdef TIMING_XY_EN
    x_pos_d   = de_d ? h_cnt_q : 12'd0;
    y_pos_d   = de_d ? v_cnt_q : 12'd0;
`endif
  end

  // State and output registers. Reset aborts the current frame at once.
  always_ff @(posedge pixe_clk) begin
    if (rest) begin
      h_cnt_q <= 12'd0;
      v_cnt_q <= 12'd0;
      de_q    <= 1'b0;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
`ifdef TIMING_XY_EN
      x_pos_q <= 12'd0;
      y_pos_q <= 12'd0;
`endif
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
`ifdef TIMING_XY_EN
      x_pos_q <= x_pos_d;
      y_pos_q <= y_pos_d;
`endif
    end
  end

  assign de    = de_q;
  assign hsync = hsync_q;
  assign vsycn = vsync_q;
`ifdef TIMING_XY_EN
  assign x_pos = x_pos_q;
  assign y_pos = y_pos_q;
`endif

endmodule

// File: tb/tb_dmt_timing_generator.sv
// Bench for dmt_timing_generator using a reduced raster so whole frames run
// quickly: H = 16 active + 2 fp + 3 sync + 4 bp = 25, V = 6 + 1 + 2 + 2 = 11,
// frame = 275 cycles. hsync active for h in 18..20, vsync for lines 7..8.
// dut_a uses active-low syncs, dut_b active-high syncs; both share reset.
// k counts negedge samples since the reset-release edge; the sample with
// k=n shows the decode of raster position n mod 275.
module tb_dmt_timing_generator;

  logic clk = 1'b0;
  logic rest = 1'b1;
  logic de_a, hsync_a, vsycn_a;
  logic de_b, hsync_b, vsycn_b;
`ifdef TIMING_XY_EN
  logic [11:0] x_pos_a, y_pos_a, x_pos_b, y_pos_b;
`endif
  logic [5:0] obs;

  int total = 0;
  int bad   = 0;
  int k     = 0;

  always #5 clk = ~clk;

  assign obs = {de_a, hsync_a, vsycn_a, de_b, hsync_b, vsycn_b};

  dmt_timing_generator #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut_a (
    .pixe_clk(clk), .rest(rest), .vsycn(vsycn_a), .hsync(hsync_a), .de(de_a)
`ifdef TIMING_XY_EN
    , .x_pos(x_pos_a), .y_pos(y_pos_a)
`endif
  );

  dmt_timing_generator #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut_b (
    .pixe_clk(clk), .rest(rest), .vsycn(vsycn_b), .hsync(hsync_b), .de(de_b)
`ifdef TIMING_XY_EN
    , .x_pos(x_pos_b), .y_pos(y_pos_b)
`endif
  );

  // Expected {de_a,hsync_a,vsycn_a,de_b,hsync_b,vsycn_b} for sample kk.
  function automatic logic [5:0] exp_out(input int kk);
    int h;
    int v;
    logic d, hs, vs;
    h  = kk % 25;
    v  = (kk / 25) % 11;
    d  = (h < 16) && (v < 6);
    hs = (h >= 18) && (h < 21);
    vs = (v >= 7) && (v < 9);
    return {d, ~hs, ~vs, d, hs, vs};
  endfunction

  task automatic step();
    @(negedge clk);
    k++;
  endtask

  task automatic test_reset();
    rest = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (obs !== 6'b011000) begin
        bad++;
        $display("FAIL reset_hold cycle %0d: got %b want %b", i, obs, 6'b011000);
      end
    end
    rest = 1'b0;
    @(negedge clk);
    k = 0;
    total++;
    if (obs !== 6'b111100) begin
      bad++;
      $display("FAIL reset_release: got %b want %b", obs, 6'b111100);
    end
  endtask

  task automatic test_line_timing();
    int de_fall, de_rise, hs_fall0, hs_fall1, hs_rise0;
    logic pde, phs;
    de_fall = -1; de_rise = -1; hs_fall0 = -1; hs_fall1 = -1; hs_rise0 = -1;
    pde = de_a;
    phs = hsync_a;
    while (k < 49) begin
      step();
      if (pde && !de_a && de_fall < 0) de_fall = k;
      if (!pde && de_a && de_rise < 0) de_rise = k;
      if (phs && !hsync_a) begin
        if (hs_fall0 < 0) hs_fall0 = k;
        else if (hs_fall1 < 0) hs_fall1 = k;
      end
      if (!phs && hsync_a && hs_rise0 < 0) hs_rise0 = k;
      pde = de_a;
      phs = hsync_a;
    end
    total++;
    if (de_fall != 16) begin
      bad++; $display("FAIL de_high_len: got %0d want 16", de_fall);
    end
    total++;
    if (de_rise - de_fall != 9) begin
      bad++; $display("FAIL de_low_len: got %0d want 9", de_rise - de_fall);
    end
    total++;
    if (hs_fall0 != 18) begin
      bad++; $display("FAIL hsync_start: got %0d want 18", hs_fall0);
    end
    total++;
    if (hs_rise0 - hs_fall0 != 3) begin
      bad++; $display("FAIL hsync_width: got %0d want 3", hs_rise0 - hs_fall0);
    end
    total++;
    if (hs_fall1 - hs_fall0 != 25) begin
      bad++; $display("FAIL hsync_period: got %0d want 25", hs_fall1 - hs_fall0);
    end
  endtask

  task automatic test_frame();
    int de_pulses, vs_fall0, vs_fall1, vs_rise0;
    logic pde, pvs;
    de_pulses = 0; vs_fall0 = -1; vs_fall1 = -1; vs_rise0 = -1;
    pde = de_a;
    pvs = vsycn_a;
    while (k < 550) begin
      step();
      total++;
      if (obs !== exp_out(k)) begin
        bad++;
        $display("FAIL frame_cycle k=%0d: got %b want %b", k, obs, exp_out(k));
      end
      if (!pde && de_a && k >= 275 && k < 550) de_pulses++;
      if (pvs && !vsycn_a) begin
        if (vs_fall0 < 0) vs_fall0 = k;
        else if (vs_fall1 < 0) vs_fall1 = k;
      end
      if (!pvs && vsycn_a && vs_rise0 < 0) vs_rise0 = k;
      pde = de_a;
      pvs = vsycn_a;
    end
    total++;
    if (de_pulses != 6) begin
      bad++; $display("FAIL de_pulses_per_frame: got %0d want 6", de_pulses);
    end
    total++;
    if (vs_fall0 != 175) begin
      bad++; $display("FAIL vsync_start: got %0d want 175", vs_fall0);
    end
    total++;
    if (vs_rise0 - vs_fall0 != 50) begin
      bad++; $display("FAIL vsync_width: got %0d want 50", vs_rise0 - vs_fall0);
    end
    total++;
    if (vs_fall1 - vs_fall0 != 275) begin
      bad++; $display("FAIL vsync_period: got %0d want 275", vs_fall1 - vs_fall0);
    end
  endtask

  task automatic test_polarity();
    int hs_b_hi, vs_b_hi, de_b_hi, hs_a_lo;
    hs_b_hi = 0; vs_b_hi = 0; de_b_hi = 0; hs_a_lo = 0;
    for (int i = 0; i < 275; i++) begin
      step();
      if (hsync_b) hs_b_hi++;
      if (vsycn_b) vs_b_hi++;
      if (de_b) de_b_hi++;
      if (!hsync_a) hs_a_lo++;
    end
    total++;
    if (hs_b_hi != 33) begin
      bad++; $display("FAIL pol_hsync_high_count: got %0d want 33", hs_b_hi);
    end
    total++;
    if (vs_b_hi != 50) begin
      bad++; $display("FAIL pol_vsync_high_count: got %0d want 50", vs_b_hi);
    end
    total++;
    if (de_b_hi != 96) begin
      bad++; $display("FAIL pol_de_count: got %0d want 96", de_b_hi);
    end
    total++;
    if (hs_a_lo != 33) begin
      bad++; $display("FAIL neg_hsync_low_count: got %0d want 33", hs_a_lo);
    end
  endtask

  task automatic test_mid_reset();
    // Line 3, pixel 10 of the current frame.
    while (k < 910) step();
    total++;
    if (obs !== 6'b111100) begin
      bad++; $display("FAIL mid_frame_before: got %b want %b", obs, 6'b111100);
    end
    rest = 1'b1;
    @(negedge clk);
    total++;
    if (obs !== 6'b011000) begin
      bad++; $display("FAIL mid_reset_out: got %b want %b", obs, 6'b011000);
    end
    rest = 1'b0;
    @(negedge clk);
    k = 0;
    total++;
    if (obs !== 6'b111100) begin
      bad++; $display("FAIL restart_origin: got %b want %b", obs, 6'b111100);
    end
    while (k < 24) begin
      step();
      total++;
      if (obs !== exp_out(k)) begin
        bad++;
        $display("FAIL restart_cycle k=%0d: got %b want %b", k, obs, exp_out(k));
      end
    end
  endtask

`ifdef TIMING_XY_EN
  task automatic test_xy();
    int h, v;
    logic d;
    while (k < 300) begin
      step();
      h = k % 25;
      v = (k / 25) % 11;
      d = (h < 16) && (v < 6);
      total++;
      if (x_pos_a !== (d ? 12'(h) : 12'd0) || y_pos_a !== (d ? 12'(v) : 12'd0)) begin
        bad++;
        $display("FAIL xy_cycle k=%0d: got x=%0d y=%0d de=%b", k, x_pos_a, y_pos_a, de_a);
      end
      if (k == 125) begin
        total++;
        if (!de_a || x_pos_a !== 12'd0 || y_pos_a !== 12'd5) begin
          bad++; $display("FAIL xy_line5_first: got x=%0d y=%0d want 0 5", x_pos_a, y_pos_a);
        end
      end
      if (k == 140) begin
        total++;
        if (!de_a || x_pos_b !== 12'd15 || y_pos_b !== 12'd5) begin
          bad++; $display("FAIL xy_frame_last: got x=%0d y=%0d want 15 5", x_pos_b, y_pos_b);
        end
      end
      if (k == 141) begin
        total++;
        if (de_a || x_pos_a !== 12'd0 || y_pos_a !== 12'd0) begin
          bad++; $display("FAIL xy_blank_zero: got x=%0d y=%0d want 0 0", x_pos_a, y_pos_a);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_line_timing();
    test_frame();
    test_polarity();
    test_mid_reset();
`ifdef TIMING_XY_EN
    test_xy();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
